// File: rtl/fnn_layer_sequencer.sv
// rtl/fnn_layer_sequencer.sv - buffers one input vector, broadcasts it to a neuron layer, collects and streams the results
module fnn_layer_sequencer #(
    parameter int numInputs     = 30,
    parameter int numNeurons    = 30,
    parameter int dataWidth     = 16,
    parameter int timeoutCycles = 64
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [dataWidth-1:0]             in_data_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    output logic [dataWidth-1:0]             nrn_in_o,
    output logic                             nrn_in_valid_o,
    input  logic [numNeurons*dataWidth-1:0]  nrn_out_i,
    input  logic [numNeurons-1:0]            nrn_outvalid_i,
    output logic [dataWidth-1:0]             out_data_o,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic                             busy_o,
    output logic                             layer_done_o,
    output logic                             timeout_err_o
);

    localparam int LW  = $clog2(numInputs + 1);
    localparam int NW  = $clog2(numNeurons + 1);
    localparam int TW  = $clog2(timeoutCycles + 1);
    localparam int IW  = (numInputs > 1) ? $clog2(numInputs) : 1;
    localparam int OW  = (numNeurons > 1) ? $clog2(numNeurons) : 1;
    localparam logic [LW-1:0] LD_LAST   = LW'(numInputs - 1);
    localparam logic [NW-1:0] NN_LAST   = NW'(numNeurons - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(timeoutCycles - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_STREAM,
        S_WAIT,
        S_OUT
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         ld_cnt_q, ld_cnt_d;
    logic [LW-1:0]         st_cnt_q, st_cnt_d;
    logic [LW-1:0]         st_nxt;
    logic [TW-1:0]         wait_cnt_q, wait_cnt_d;
    logic [NW-1:0]         out_cnt_q, out_cnt_d;
    logic [numNeurons-1:0] mask_q, mask_d;
    logic [dataWidth-1:0]  nrn_in_q, nrn_in_d;
    logic                  nrn_in_valid_q, nrn_in_valid_d;
    logic                  layer_done_q, layer_done_d;
    logic                  timeout_err_q, timeout_err_d;

    logic [dataWidth-1:0]  in_buf_q  [numInputs];
    logic [dataWidth-1:0]  res_buf_q [numNeurons];

    logic                  in_we;
    logic [numNeurons-1:0] cap_vec;
    logic [numNeurons-1:0] zero_vec;

    assign in_ready_o     = (state_q == S_LOAD) && !rst_i;
    assign nrn_in_o       = nrn_in_q;
    assign nrn_in_valid_o = nrn_in_valid_q;
    assign out_valid_o    = (state_q == S_OUT);
    assign out_data_o     = out_valid_o ? res_buf_q[out_cnt_q[OW-1:0]] : '0;
    assign busy_o         = !((state_q == S_LOAD) && (ld_cnt_q == '0));
    assign layer_done_o   = layer_done_q;
    assign timeout_err_o  = timeout_err_q;
    assign st_nxt         = st_cnt_q + LW'(1);

    always_comb begin
        state_d        = state_q;
        ld_cnt_d       = ld_cnt_q;
        st_cnt_d       = st_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        out_cnt_d      = out_cnt_q;
        mask_d         = mask_q;
        nrn_in_d       = '0;
        nrn_in_valid_d = 1'b0;
        layer_done_d   = 1'b0;
        timeout_err_d  = timeout_err_q;
        in_we          = 1'b0;
        cap_vec        = '0;
        zero_vec       = '0;

        case (state_q)
            S_LOAD: begin
                if (in_valid_i && in_ready_o) begin
                    in_we = 1'b1;
                    if (ld_cnt_q == LD_LAST) begin
                        // First broadcast sample is registered here so the burst starts the very next cycle.
                        state_d        = S_STREAM;
                        ld_cnt_d       = '0;
                        st_cnt_d       = '0;
                        nrn_in_valid_d = 1'b1;
                        nrn_in_d       = (numInputs == 1) ? in_data_i : in_buf_q[0];
                    end else begin
                        ld_cnt_d = ld_cnt_q + LW'(1);
                    end
                end
            end
            S_STREAM: begin
                cap_vec = nrn_outvalid_i & ~mask_q;
                mask_d  = mask_q | cap_vec;
                if (st_cnt_q == LD_LAST) begin
                    state_d    = S_WAIT;
                    st_cnt_d   = '0;
                    wait_cnt_d = '0;
                end else begin
                    st_cnt_d       = st_nxt;
                    nrn_in_valid_d = 1'b1;
                    nrn_in_d       = in_buf_q[st_nxt[IW-1:0]];
                end
            end
            S_WAIT: begin
                cap_vec    = nrn_outvalid_i & ~mask_q;
                mask_d     = mask_q | cap_vec;
                wait_cnt_d = wait_cnt_q + TW'(1);
                if (&mask_d) begin
                    state_d    = S_OUT;
                    wait_cnt_d = '0;
                    out_cnt_d  = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Silent neurons report zero so downstream still receives a full vector.
                    state_d       = S_OUT;
                    wait_cnt_d    = '0;
                    out_cnt_d     = '0;
                    timeout_err_d = 1'b1;
                    zero_vec      = ~mask_d;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    if (out_cnt_q == NN_LAST) begin
                        state_d      = S_LOAD;
                        out_cnt_d    = '0;
                        mask_d       = '0;
                        layer_done_d = 1'b1;
                    end else begin
                        out_cnt_d = out_cnt_q + NW'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_LOAD;
            ld_cnt_q       <= '0;
            st_cnt_q       <= '0;
            wait_cnt_q     <= '0;
            out_cnt_q      <= '0;
            mask_q         <= '0;
            nrn_in_q       <= '0;
            nrn_in_valid_q <= 1'b0;
            layer_done_q   <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ld_cnt_q       <= ld_cnt_d;
            st_cnt_q       <= st_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            out_cnt_q      <= out_cnt_d;
            mask_q         <= mask_d;
            nrn_in_q       <= nrn_in_d;
            nrn_in_valid_q <= nrn_in_valid_d;
            layer_done_q   <= layer_done_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_we) begin
            in_buf_q[ld_cnt_q[IW-1:0]] <= in_data_i;
        end
        for (int k = 0; k < numNeurons; k++) begin
            if (cap_vec[k]) begin
                res_buf_q[k] <= nrn_out_i[k*dataWidth +: dataWidth];
            end else if (zero_vec[k]) begin
                res_buf_q[k] <= '0;
            end
        end
    end

endmodule
